// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between two Avalon-MM pipelined requesters, the arbiter and a
// single-port on-chip RAM. The arbiter sits on the slave modport; the
// environment (requesters plus RAM) sits on the master modport.
interface onchip_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BE_W   = 4
);

   // Requester 0
   logic [ADDR_W-1:0] m0_address;
   logic [BE_W-1:0]   m0_byteenable;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   // Requester 1
   logic [ADDR_W-1:0] m1_address;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   // RAM pins
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   // Arbiter side
   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

   // Environment side: requesters and the RAM
   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );

endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// One transfer per clock; read returns are routed by an RD_LAT-deep tag pipe.
// Optional performance counters are built when ONCHIP_MEM_ARB_PERF_EN is defined.
module onchip_mem_arbiter #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BE_W   = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   onchip_mem_arbiter_if.slave bus
`ifdef ONCHIP_MEM_ARB_PERF_EN
   ,
   input  logic                perf_clear,
   output logic [31:0]         perf_grant0,
   output logic [31:0]         perf_grant1,
   output logic [31:0]         perf_conflict
`endif
);

   localparam int unsigned Tail = RD_LAT - 1;

   logic req0, req1;
   logic gnt0, gnt1;
   logic last_grant_q, last_grant_d;

   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
   logic [BE_W-1:0]   hold_be_q, hold_be_d;
   logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

   // Tag pipe: valid marks a read in flight, id names its owner (1 = m1)
   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0] tag_id_q, tag_id_d;
   logic              push_vld;

   // Request decode and grant; both lose while reset is held
   always_comb begin
      req0 = bus.m0_read | bus.m0_write;
      req1 = bus.m1_read | bus.m1_write;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && req1) begin
            // last_grant_q = 1 means m1 won last time, so m0 goes now
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // Round-robin pointer follows the winner, holds when idle
   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt1) begin
         last_grant_d = 1'b1;
      end else if (gnt0) begin
         last_grant_d = 1'b0;
      end
   end

   // Stall outputs: everyone waits during reset
   always_comb begin
      bus.m0_waitrequest = reset | (req0 & ~gnt0);
      bus.m1_waitrequest = reset | (req1 & ~gnt1);
   end

   // RAM address/data mux; keep the last granted values when idle
   always_comb begin
      hold_addr_d  = hold_addr_q;
      hold_be_d    = hold_be_q;
      hold_wdata_d = hold_wdata_q;
      if (gnt0) begin
         hold_addr_d  = bus.m0_address;
         hold_be_d    = bus.m0_byteenable;
         hold_wdata_d = bus.m0_writedata;
      end else if (gnt1) begin
         hold_addr_d  = bus.m1_address;
         hold_be_d    = bus.m1_byteenable;
         hold_wdata_d = bus.m1_writedata;
      end
      bus.mem_address    = hold_addr_d;
      bus.mem_byteenable = hold_be_d;
      bus.mem_writedata  = hold_wdata_d;
      bus.mem_chipselect = gnt0 | gnt1;
      bus.mem_write      = (gnt0 & bus.m0_write) | (gnt1 & bus.m1_write);
      bus.mem_clken      = ~reset;
   end

   // Tag pipe shift; a read that is also a write is dropped
   always_comb begin
      push_vld = (gnt0 & bus.m0_read & ~bus.m0_write) | (gnt1 & bus.m1_read & ~bus.m1_write);
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = push_vld;
      tag_id_d[0]  = gnt1;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   // Read return routing; the gate on reset drops reads caught in flight
   always_comb begin
      bus.m0_readdatavalid = ~reset & tag_vld_q[Tail] & ~tag_id_q[Tail];
      bus.m1_readdatavalid = ~reset & tag_vld_q[Tail] & tag_id_q[Tail];
      bus.m0_readdata      = bus.mem_readdata;
      bus.m1_readdata      = bus.mem_readdata;
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
         hold_addr_q  <= '0;
         hold_be_q    <= '0;
         hold_wdata_q <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         hold_addr_q  <= hold_addr_d;
         hold_be_q    <= hold_be_d;
         hold_wdata_q <= hold_wdata_d;
      end
   end

`ifdef ONCHIP_MEM_ARB_PERF_EN
   logic [31:0] perf_g0_q, perf_g0_d;
   logic [31:0] perf_g1_q, perf_g1_d;
   logic [31:0] perf_cf_q, perf_cf_d;

   // Saturating event counters; clear wins over a coincident event
   always_comb begin
      perf_g0_d = perf_g0_q;
      perf_g1_d = perf_g1_q;
      perf_cf_d = perf_cf_q;
      if (perf_clear) begin
         perf_g0_d = '0;
         perf_g1_d = '0;
         perf_cf_d = '0;
      end else begin
         if (gnt0 && (perf_g0_q != '1)) perf_g0_d = perf_g0_q + 32'd1;
         if (gnt1 && (perf_g1_q != '1)) perf_g1_d = perf_g1_q + 32'd1;
         if (req0 && req1 && (perf_cf_q != '1)) perf_cf_d = perf_cf_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_g0_q <= '0;
         perf_g1_q <= '0;
         perf_cf_q <= '0;
      end else begin
         perf_g0_q <= perf_g0_d;
         perf_g1_q <= perf_g1_d;
         perf_cf_q <= perf_cf_d;
      end
   end

   assign perf_grant0   = perf_g0_q;
   assign perf_grant1   = perf_g1_q;
   assign perf_conflict = perf_cf_q;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomised scoreboard bench for onchip_mem_arbiter with a behavioural RAM.
module tb_onchip_mem_arbiter;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned RD_LAT = 1;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [12:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } cmd_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   localparam cmd_t Idle = '{rd: 1'b0, wr: 1'b0, addr: 13'd0, be: 4'd0, data: 32'd0};

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

`ifdef ONCHIP_MEM_ARB_PERF_EN
   logic        perf_clear = 1'b0;
   logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

   onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef ONCHIP_MEM_ARB_PERF_EN
      ,
      .perf_clear   (perf_clear),
      .perf_grant0  (perf_grant0),
      .perf_grant1  (perf_grant1),
      .perf_conflict(perf_conflict)
`endif
   );

   cmd_t cmd0 = '0;
   cmd_t cmd1 = '0;
   assign bus.m0_read       = cmd0.rd;
   assign bus.m0_write      = cmd0.wr;
   assign bus.m0_address    = cmd0.addr;
   assign bus.m0_byteenable = cmd0.be;
   assign bus.m0_writedata  = cmd0.data;
   assign bus.m1_read       = cmd1.rd;
   assign bus.m1_write      = cmd1.wr;
   assign bus.m1_address    = cmd1.addr;
   assign bus.m1_byteenable = cmd1.be;
   assign bus.m1_writedata  = cmd1.data;

   // Behavioural RAM: registered address and data, unregistered output
   logic [31:0] ram [8192];
   logic [12:0] ram_raddr_q = '0;
   always @(posedge clk) begin
      if (bus.mem_clken && bus.mem_chipselect) begin
         if (bus.mem_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_byteenable[b]) ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
         end else begin
            ram_raddr_q <= bus.mem_address;
         end
      end
   end
   assign bus.mem_readdata = ram[ram_raddr_q];

   // Reference state
   logic [31:0] ref_mem [8192];
   int          last_win = 1;
   logic [12:0] hold_addr;
   bit          hold_known = 0;
   int          wait0 = 0, wait1 = 0;
   exp_t        q0[$], q1[$];
   int          cyc = 0;
   int          n_checks = 0, n_errors = 0;
`ifdef ONCHIP_MEM_ARB_PERF_EN
   logic [31:0] m_g0 = 0, m_g1 = 0, m_cf = 0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // One clock: predict from the current commands, check the DUT, update the model
   task automatic step(output bit acc0, output bit acc1);
      bit r0, r1, g0, g1;
      cmd_t c;
      exp_t e;
      @(negedge clk);
      r0 = cmd0.rd | cmd0.wr;
      r1 = cmd1.rd | cmd1.wr;
      g0 = 0;
      g1 = 0;
      if (!reset) begin
         if (r0 && r1) begin
            // contention: the one that did not win last time
            if (last_win == 0) g1 = 1; else g0 = 1;
         end else begin
            g0 = r0;
            g1 = r1;
         end
      end
      chk("m0_waitrequest", bus.m0_waitrequest, reset | (r0 & !g0));
      chk("m1_waitrequest", bus.m1_waitrequest, reset | (r1 & !g1));
      chk("mem_chipselect", bus.mem_chipselect, g0 | g1);
      chk("mem_clken", bus.mem_clken, !reset);
`ifdef ONCHIP_MEM_ARB_PERF_EN
      chk("perf_grant0", perf_grant0, m_g0);
      chk("perf_grant1", perf_grant1, m_g1);
      chk("perf_conflict", perf_conflict, m_cf);
      if (reset || perf_clear) begin
         m_g0 = 0; m_g1 = 0; m_cf = 0;
      end else begin
         m_g0 += 32'(g0);
         m_g1 += 32'(g1);
         m_cf += 32'(r0 & r1);
      end
`endif
      if (reset) begin
         last_win   = 1;
         hold_known = 0;
         wait0      = 0;
         wait1      = 0;
         chk("mem_write_rst", bus.mem_write, 1'b0);
      end else begin
         wait0 = (r0 && !g0) ? wait0 + 1 : 0;
         wait1 = (r1 && !g1) ? wait1 + 1 : 0;
         if (wait0 > 1) chk("m0_max_wait", wait0, 1);
         if (wait1 > 1) chk("m1_max_wait", wait1, 1);
         if (g0 || g1) begin
            c = g0 ? cmd0 : cmd1;
            chk("mem_write", bus.mem_write, c.wr);
            chk("mem_address", bus.mem_address, c.addr);
            if (c.wr) begin
               chk("mem_byteenable", bus.mem_byteenable, c.be);
               chk("mem_writedata", bus.mem_writedata, c.data);
               ref_mem[c.addr] = merge(ref_mem[c.addr], c.data, c.be);
            end else begin
               e.data = ref_mem[c.addr];
               e.due  = cyc + RD_LAT;
               if (g0) q0.push_back(e); else q1.push_back(e);
            end
            last_win   = g1 ? 1 : 0;
            hold_addr  = c.addr;
            hold_known = 1;
         end else begin
            chk("mem_write_idle", bus.mem_write, 1'b0);
            if (hold_known) chk("mem_address_hold", bus.mem_address, hold_addr);
         end
      end
      acc0 = g0;
      acc1 = g1;
      @(posedge clk);
      #1;
   endtask

   // Return-path monitor for one requester
   task automatic mon(input int p, input logic v, input logic [31:0] d);
      bit   have;
      exp_t e;
      have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (p == 0) ? q0[0] : q1[0];
      if (v) begin
         if (!have) begin
            chk(p == 0 ? "m0_rdv_unexpected" : "m1_rdv_unexpected", v, 1'b0);
         end else begin
            chk(p == 0 ? "m0_rd_latency" : "m1_rd_latency", cyc, e.due);
            chk(p == 0 ? "m0_readdata" : "m1_readdata", d, e.data);
            if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
      end else if (have && e.due <= cyc) begin
         chk(p == 0 ? "m0_rdv_missing" : "m1_rdv_missing", v, 1'b1);
         if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("m0_rdv_reset", bus.m0_readdatavalid, 1'b0);
         chk("m1_rdv_reset", bus.m1_readdatavalid, 1'b0);
         q0.delete();
         q1.delete();
      end else begin
         mon(0, bus.m0_readdatavalid, bus.m0_readdata);
         mon(1, bus.m1_readdatavalid, bus.m1_readdata);
      end
   end

   function automatic cmd_t mk(input bit rd, input bit wr, input logic [12:0] a,
                               input logic [3:0] be, input logic [31:0] d);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      int k;
      logic [12:0] a;
      k = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
      if (k < 25) return Idle;
      return mk(k < 65 || k >= 92, k >= 65, a, 4'($urandom_range(1, 15)), $urandom);
   endfunction

   task automatic xfer(input int p, input cmd_t c);
      bit a0, a1, done;
      done = 0;
      if (p == 0) cmd0 = c; else cmd1 = c;
      for (int i = 0; i < 4 && !done; i++) begin
         step(a0, a1);
         done = (p == 0) ? a0 : a1;
      end
      chk("xfer_accepted", done, 1'b1);
      if (p == 0) cmd0 = Idle; else cmd1 = Idle;
   endtask

   task automatic idle(input int n);
      bit a0, a1;
      for (int i = 0; i < n; i++) step(a0, a1);
   endtask

   initial begin
      bit a0, a1;
      for (int i = 0; i < 8192; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      idle(2);
      reset = 1'b0;
      idle(2);

      // write then back-to-back read
      xfer(0, mk(0, 1, 13'h0010, 4'hF, 32'hDEADBEEF));
      xfer(0, mk(1, 0, 13'h0010, 4'hF, 32'h0));
      idle(3);

      // partial write over all-ones, read by the other requester
      xfer(1, mk(0, 1, 13'h1FFF, 4'hF, 32'hFFFFFFFF));
      xfer(1, mk(0, 1, 13'h1FFF, 4'h3, 32'h0000AAAA));
      xfer(0, mk(1, 0, 13'h1FFF, 4'hF, 32'h0));
      idle(3);

      // contention straight after reset
      xfer(0, mk(0, 1, 13'h0001, 4'hF, 32'h11111111));
      xfer(1, mk(0, 1, 13'h0002, 4'hF, 32'h22222222));
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      cmd0 = mk(1, 0, 13'h0001, 4'hF, 32'h0);
      cmd1 = mk(1, 0, 13'h0002, 4'hF, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(a0, a1);
         chk("contend_m0_turn", a0, (i % 2 == 0));
      end
      cmd0 = Idle;
      cmd1 = Idle;
      idle(3);

      // read in flight when reset arrives
      cmd0 = mk(1, 0, 13'h0010, 4'hF, 32'h0);
      step(a0, a1);
      cmd0 = Idle;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(4);

      // read and write together: write wins, no return
      xfer(0, mk(1, 1, 13'h0004, 4'hF, 32'h12345678));
      idle(3);
      xfer(1, mk(1, 0, 13'h0004, 4'hF, 32'h0));
      idle(3);

      // randomised traffic with occasional resets
      cmd0 = rand_cmd();
      cmd1 = rand_cmd();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
`ifdef ONCHIP_MEM_ARB_PERF_EN
         perf_clear = ($urandom_range(0, 99) == 0);
`endif
         step(a0, a1);
         if (a0 || !(cmd0.rd || cmd0.wr)) cmd0 = rand_cmd();
         if (a1 || !(cmd1.rd || cmd1.wr)) cmd1 = rand_cmd();
      end
      reset = 1'b0;
`ifdef ONCHIP_MEM_ARB_PERF_EN
      perf_clear = 1'b0;
`endif
      cmd0 = Idle;
      cmd1 = Idle;
      idle(5);
      chk("outstanding_reads", q0.size() + q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Two-requester arbiter sharing one single-port 8192x32 on-chip RAM. The RAM has registered address/data, unregistered output, and a 1-cycle read latency.
- Presents two Avalon-MM pipelined slave ports (m0, m1) with waitrequest/readdatavalid.
- Drives the RAM's address/byteenable/chipselect/write/writedata/clken pins.
- Round-robin arbitration, one transfer per clock, read-return routing by an in-flight tag pipeline.

Parameters:
ADDR_W, 13, word address width (RAM depth 2^ADDR_W)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_address  in  ADDR_W  requester 0 word address
m0_byteenable  in  BE_W  requester 0 byte lanes
m0_read  in  1  requester 0 read request
m0_write  in  1  requester 0 write request
m0_writedata  in  DATA_W  requester 0 write data
m0_waitrequest  out  1  requester 0 stall
m0_readdata  out  DATA_W  requester 0 read data
m0_readdatavalid  out  1  requester 0 read data valid
m1_*  same set as m0_*, for requester 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, the write is performed, the read is dropped, and no readdatavalid is returned for it.
- Grant (combinational, same cycle):
  - Only one request active: that requester is granted.
  - Both active: the requester NOT in register last_grant is granted.
  - last_grant updates to the winner on every granted cycle and holds when idle.
- Stall: mN_waitrequest = reqN & ~grantN. An ungranted requester must hold its address/data/command stable until its waitrequest is low.
- Mux: mem_address, mem_byteenable and mem_writedata come from the granted requester, or are held at the last value when idle.
  - mem_chipselect = any grant.
  - mem_write = granted write.
  - mem_clken = 1 except during reset.
- Read tracking: a granted read pushes {valid=1, id=N} into an RD_LAT-deep shift register; all other cycles push valid=0. The shift register advances every cycle.
- Read return:
  - Tail entry valid with id N: mN_readdatavalid=1 and mN_readdata=mem_readdata.
  - Readdata to the non-owner is don't-care; the implementation drives it with the same mem_readdata.
- Throughput and latency:
  - One transfer per cycle.
  - Read latency from grant to readdatavalid = RD_LAT cycles exactly.
  - Writes complete in the grant cycle.
  - No back-pressure on the return path.
- Under continuous contention, grants alternate m0,m1,m0,... Maximum wait for either requester is 1 cycle.
- Same address, back-to-back write (mX) then read (mY): the read returns the new data (RAM write completes before the next-cycle read).
- Reset state:
  - last_grant=1, so m0 wins the first contention.
  - Tag pipeline cleared; readdatavalid=0.
  - While reset is high, both waitrequests=1, mem_chipselect=0, mem_write=0, mem_clken=0.
  - Mid-operation reset: in-flight reads are discarded and no readdatavalid is issued afterwards for them. The first cycle after reset deasserts behaves as idle state.
- Registers: last_grant, the tag pipeline, and the held mem_* mux values when idle.

Optional Feature:
ONCHIP_MEM_ARB_PERF_EN
- With the macro: adds outputs perf_grant0[31:0], perf_grant1[31:0] and perf_conflict[31:0].
  - perf_grant0/1 count granted transfers per requester.
  - perf_conflict counts cycles with both requests active.
  - All counters saturate at 0xFFFFFFFF and clear on reset.
  - Input perf_clear (1 bit) zeroes all three synchronously; if it coincides with an event, the counter goes to 0.
- Without the macro: the ports and counters do not exist.

Test Plan:
- Idle then m0 write addr 0x0010, data 0xDEADBEEF, be 0xF -> same cycle: mem_write=1, mem_address=0x0010, m0_waitrequest=0.
- m0 read 0x0010 the next cycle -> m0_readdatavalid=1 one cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- First cycle after reset, m0 and m1 both read (0x0001, 0x0002) for 4 cycles -> grant order m0,m1,m0,m1; each waitrequest high on alternate cycles; readdatavalid alternates with the correct words.
- m1 write 0x1FFF be 0x3 data 0x0000AAAA over prior 0xFFFFFFFF, then m0 read 0x1FFF -> returns 0xFFFFAAAA.
- m0 read issued, reset asserted the following cycle -> no m0_readdatavalid; during reset both waitrequests=1 and mem_chipselect=0.
- m0 asserts read and write together at 0x0004 -> write occurs, no readdatavalid; with ONCHIP_MEM_ARB_PERF_EN, perf_grant0 increments by 1.
